// File: rtl/io_bus_pkg.sv
// Shared constants for the io_bus peripheral interconnect.
// Holds the transaction FSM encoding and the default ack timeout.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT = 15;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/io_bus_decode.sv
// io_decode: combinational address decoder for io_bus.
// Produces a one-hot hit for the lowest-index matching slave and a miss flag.
module io_decode #(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [NUM_SLAVES-1:0] o_hit,
    output logic                  o_miss
);

    logic [NUM_SLAVES-1:0] w_raw;

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_match
        assign w_raw[k] = (i_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W];
    end

    // x & -x keeps only the lowest set bit, giving lowest-index priority
    assign o_hit  = w_raw & (~w_raw + NUM_SLAVES'(1));
    assign o_miss = ~|w_raw;

endmodule

// File: rtl/io_bus.sv
// io_bus: single-master to NUM_SLAVES peripheral bridge with address decode,
// registered request outputs, per-access ack timeout and error response.
module io_bus
    import io_bus_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            ADDR_W     = 32,
    parameter int                            DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK = '0,
    parameter int                            TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          be_i,
    output logic                         ready_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         err_o,
    output logic [NUM_SLAVES-1:0]        sel_o,
    output logic                         we_o,
    output logic [ADDR_W-1:0]            addr_o,
    output logic [DATA_W-1:0]            wdata_o,
    output logic [DATA_W/8-1:0]          be_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] rdata_i,
    input  logic [NUM_SLAVES-1:0]        ack_i
);

    localparam int               BE_W    = DATA_W / 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_SLAVES-1:0] r_sel, w_hit;
    logic                  w_miss, w_ack, w_timeout;
    logic                  r_err, r_we;
    logic [DATA_W-1:0]     r_rdata, r_wdata, w_slv_rdata;
    logic [ADDR_W-1:0]     r_addr;
    logic [BE_W-1:0]       r_be;

    io_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .i_addr (addr_i),
        .o_hit  (w_hit),
        .o_miss (w_miss)
    );

    assign w_ack     = |(ack_i & r_sel);
    // the edge that bumps the counter to TIMEOUT is the one that gives up
    assign w_timeout = (r_cnt == TO_LAST);

    always_comb begin
        w_slv_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel[k]) w_slv_rdata = w_slv_rdata | rdata_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_i) w_next = w_miss ? ST_RESP : ST_WAIT;
            ST_WAIT: if (w_ack || w_timeout) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (r_state == ST_RESP);
        err_o   = (r_state == ST_RESP) && r_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        // on a miss w_hit is zero, so sel stays low and the error is flagged
                        r_sel   <= w_hit;
                        r_err   <= w_miss;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_be    <= be_i;
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_sel   <= '0;
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_slv_rdata;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            r_sel   <= '0;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_o   = r_sel;
    assign rdata_o = r_rdata;
    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign be_o    = r_be;

endmodule
